// File: rtl/pulse_stretch.sv
// Strobe-to-level stretcher: holds `level` high for a programmable length,
// then forces a fixed low gap so every request produces a distinct rising edge.
module pulse_stretch #(
  parameter int CW  = 8,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [CW-1:0] len,
  input  logic          retrig,
  output logic          level,
  output logic          done,
  output logic [CW-1:0] remain,
  output logic          pend
);

  typedef enum logic [1:0] {IDLE, HOLD, GAPW} state_t;

  state_t        state;
  logic [7:0]    gcnt;
  logic [CW-1:0] pend_len;
  logic [CW-1:0] eff_len;

  assign eff_len = (len == '0) ? CW'(1) : len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      level    <= 1'b0;
      done     <= 1'b0;
      remain   <= '0;
      pend     <= 1'b0;
      pend_len <= '0;
      gcnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state  <= HOLD;
            level  <= 1'b1;
            remain <= eff_len;
          end
        end
        HOLD: begin
          if (trig && retrig) begin
            remain <= eff_len;
          end else begin
            // one-deep queue keeps the oldest request
            if (trig && !pend) begin
              pend     <= 1'b1;
              pend_len <= eff_len;
            end
            if (remain == CW'(1)) begin
              state  <= GAPW;
              level  <= 1'b0;
              done   <= 1'b1;
              remain <= '0;
              gcnt   <= 8'(GAP);
            end else begin
              remain <= remain - CW'(1);
            end
          end
        end
        GAPW: begin
          if (gcnt == 8'd1) begin
            if (pend) begin
              // queued request is served first; a strobe on this edge takes its slot
              state  <= HOLD;
              level  <= 1'b1;
              remain <= pend_len;
              pend   <= trig;
              if (trig) pend_len <= eff_len;
            end else if (trig) begin
              state  <= HOLD;
              level  <= 1'b1;
              remain <= eff_len;
            end else begin
              state <= IDLE;
            end
          end else begin
            gcnt <= gcnt - 8'd1;
            if (trig && !pend) begin
              pend     <= 1'b1;
              pend_len <= eff_len;
            end
          end
        end
        default: begin
          state  <= IDLE;
          level  <= 1'b0;
          remain <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench: a timestamp model predicts every output cycle; a monitor
// on the falling edge pops and compares against the DUT.
module tb_pulse_stretch;
  localparam int CW  = 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset, trig, retrig;
  logic [CW-1:0] len;
  logic          level, done, pend;
  logic [CW-1:0] remain;

  typedef struct {
    logic          lvl;
    logic          dn;
    logic [CW-1:0] rem;
    logic          pd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b1;

  pulse_stretch #(.CW(CW), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .trig(trig), .len(len), .retrig(retrig),
    .level(level), .done(done), .remain(remain), .pend(pend)
  );

  always #5 clk = ~clk;

  // Reference: a hold is the cycle interval [hs, he]; the gap is the GAP
  // cycles after he; queued lengths live in a plain queue (depth 1).
  int cyc = 0;
  int hs  = 0;
  int he  = -100;
  int pq[$];

  always @(posedge clk) begin
    automatic int   l = (len == 0) ? 1 : int'(len);
    automatic bit   in_hold = (hs <= cyc) && (cyc <= he);
    automatic bit   in_gap  = (cyc > he) && (cyc <= he + GAP);
    automatic int   n;
    automatic exp_t e;
    if (reset) begin
      hs = 0; he = -100; pq.delete();
    end else if (in_hold) begin
      if (trig && retrig) he = cyc + l;
      else if (trig && pq.size() == 0) pq.push_back(l);
    end else if (in_gap) begin
      if (cyc == he + GAP) begin
        if (pq.size() > 0) begin
          hs = cyc + 1; he = cyc + pq.pop_front();
          if (trig) pq.push_back(l);
        end else if (trig) begin
          hs = cyc + 1; he = cyc + l;
        end
      end else if (trig && pq.size() == 0) begin
        pq.push_back(l);
      end
    end else if (trig) begin
      hs = cyc + 1; he = cyc + l;
    end
    n     = cyc + 1;
    e.lvl = (hs <= n) && (n <= he);
    e.rem = e.lvl ? CW'(he - n + 1) : '0;
    e.dn  = !e.lvl && (n == he + 1);
    e.pd  = pq.size() > 0;
    exp_q.push_back(e);
    cyc++;
  end

  int starve = 0;
  always @(negedge clk) begin
    if (running) begin
      if (exp_q.size() == 0) begin
        starve++;
        if (starve > 2) begin
          checks++; errors++;
          $display("FAIL starve: no expected entry for %0d cycles", starve);
          starve = 0;
        end
      end else begin
        automatic exp_t e = exp_q.pop_front();
        starve = 0;
        checks++;
        if (level !== e.lvl || done !== e.dn || remain !== e.rem || pend !== e.pd) begin
          errors++;
          $display("FAIL cycle %0d: got level=%b done=%b remain=%0d pend=%b, want level=%b done=%b remain=%0d pend=%b",
                   cyc, level, done, remain, pend, e.lvl, e.dn, e.rem, e.pd);
        end
      end
    end
  end

  task automatic drive(input bit t, input int l, input bit rt, input bit rs);
    @(negedge clk);
    trig = t; len = CW'(l); retrig = rt; reset = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; trig = 1'b0; len = '0; retrig = 1'b0;
    repeat (3) @(posedge clk);
    // basic hold, len=3
    drive(1, 3, 0, 0); idle(8);
    // len=0 treated as 1
    drive(1, 0, 0, 0); idle(6);
    // retrigger extends the hold
    drive(1, 4, 1, 0); drive(0, 0, 1, 0); drive(1, 5, 1, 0); idle(10);
    // queued request plus dropped extras
    drive(1, 3, 0, 0); drive(1, 2, 0, 0); drive(1, 2, 0, 0); drive(1, 2, 0, 0); idle(12);
    // strobe on the last gap edge, nothing pending
    drive(1, 2, 0, 0); idle(1); drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(1, 3, 0, 0); idle(8);
    // strobe on the last gap edge with a request pending
    drive(1, 2, 0, 0); drive(1, 4, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(1, 1, 0, 0); idle(14);
    // reset mid-hold together with a strobe
    drive(1, 6, 0, 0); drive(0, 0, 0, 0); drive(1, 3, 0, 0); drive(1, 5, 0, 1); idle(8);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      automatic bit t  = ($urandom_range(99) < 30);
      automatic int l  = ($urandom_range(9) == 0) ? $urandom_range(255) : $urandom_range(6);
      automatic bit rt = ((i / 64) % 2) == 1;
      automatic bit rs = ($urandom_range(199) == 0);
      drive(t, l, rt, rs);
    end
    idle(300);
    @(negedge clk);
    running = 1'b0;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
